// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_if
// Description : Bundle of the two writeback requesters (A = pipeline
//               writeback, B = multi-cycle unit) and the register-file write
//               port produced by the arbiter.
//   master : requester/testbench side; drives valid/addr/data and observes
//            ready, the register-file write port and the status flags.
//   slave  : arbiter side.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    // Requester A
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    // Requester B
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    // Register-file write port and status
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              sel_b;
    logic              b_forced;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  a_ready, b_ready,
        input  rf_we, rf_waddr, rf_wdata, sel_b, b_forced
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output a_ready, b_ready,
        output rf_we, rf_waddr, rf_wdata, sel_b, b_forced
    );
endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Arbitrates the single register-file write port between the
//               pipeline writeback (A, priority) and the multi-cycle unit (B).
//               B may be refused at most MAX_WAIT consecutive cycles; it is
//               then force-granted for one cycle while A is stalled.
//               The write port is registered (one cycle after the transfer).
// Ports       : Clk    - clock, rising edge
//               Rst_n  - asynchronous active-low reset
//               bus    - requester handshakes + register-file write port
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4      // legal 1..15
) (
    input  wire logic          Clk,
    input  wire logic          Rst_n,
    wb_port_arbiter_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_NORMAL  = 1'b0,
        ST_FORCE_B = 1'b1
    } state_t;

    localparam logic [3:0] c_wait_max  = 4'(MAX_WAIT);
    localparam logic [3:0] c_wait_last = 4'(MAX_WAIT - 1);

    state_t            state_q,    state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              rf_we_q,    rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              sel_b_q,    sel_b_d;

    logic w_a_ready;
    logic w_b_ready;
    logic w_a_xfer;
    logic w_b_xfer;

    // ------------------------------------------------------------------
    // Next-state, handshake and write-port logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        sel_b_d    = sel_b_q;

        // Ready depends only on state and the other requester's valid,
        // never on a requester's own addr/data.
        if (state_q == ST_FORCE_B) begin
            w_a_ready = 1'b0;
            w_b_ready = 1'b1;
        end else begin
            w_a_ready = 1'b1;
            w_b_ready = !bus.a_valid;
        end

        w_a_xfer = bus.a_valid && w_a_ready;
        w_b_xfer = bus.b_valid && w_b_ready;

        case (state_q)
            ST_NORMAL: begin
                if (w_b_xfer) begin
                    wait_cnt_d = 4'd0;
                end else if (bus.b_valid) begin
                    // B refused this cycle
                    if (wait_cnt_q < c_wait_max) begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                    if (wait_cnt_q == c_wait_last) begin
                        state_d = ST_FORCE_B;
                    end
                end
            end
            ST_FORCE_B: begin
                // B holds valid, so this transfer happens on the first
                // FORCE_B cycle; otherwise keep waiting in FORCE_B.
                if (w_b_xfer) begin
                    state_d    = ST_NORMAL;
                    wait_cnt_d = 4'd0;
                end
            end
            default: begin
                state_d    = ST_NORMAL;
                wait_cnt_d = 4'd0;
            end
        endcase

        // A and B transfers are mutually exclusive by construction.
        // Register 0 writes complete the handshake but never strobe rf_we.
        if (w_a_xfer) begin
            rf_we_d    = (bus.a_addr != '0);
            rf_waddr_d = bus.a_addr;
            rf_wdata_d = bus.a_data;
            sel_b_d    = 1'b0;
        end else if (w_b_xfer) begin
            rf_we_d    = (bus.b_addr != '0);
            rf_waddr_d = bus.b_addr;
            rf_wdata_d = bus.b_data;
            sel_b_d    = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_NORMAL;
            wait_cnt_q <= 4'd0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            sel_b_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            sel_b_q    <= sel_b_d;
        end
    end

    assign bus.a_ready  = w_a_ready;
    assign bus.b_ready  = w_b_ready;
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.sel_b    = sel_b_q;
    assign bus.b_forced = (state_q == ST_FORCE_B);

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Directed testbench for wb_port_arbiter. Main instance uses
//               MAX_WAIT = 4; a second instance with MAX_WAIT = 1 checks
//               strict A/B alternation under contention.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    logic Clk;
    logic Rst_n;
    int   n_vec;
    int   n_bad;
    logic m1_on;

    wb_port_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    wb_port_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();

    wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_WAIT(4)) u_dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_WAIT(1)) u_dut_m1 (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus1)
    );

    // Second instance: both requesters contend whenever m1_on is set
    assign bus1.a_valid = m1_on;
    assign bus1.a_addr  = 5'd1;
    assign bus1.a_data  = 32'h0000_00A1;
    assign bus1.b_valid = m1_on;
    assign bus1.b_addr  = 5'd2;
    assign bus1.b_data  = 32'h0000_00B2;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        m1_on = 1'b0;
        Rst_n = 1'b0;
        bus.a_valid = 1'b0;
        bus.a_addr  = '0;
        bus.a_data  = '0;
        bus.b_valid = 1'b0;
        bus.b_addr  = '0;
        bus.b_data  = '0;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_rf_we",    bus.rf_we,    0);
        chk("rst_waddr",    bus.rf_waddr, 0);
        chk("rst_wdata",    bus.rf_wdata, 0);
        chk("rst_sel_b",    bus.sel_b,    0);
        chk("rst_b_forced", bus.b_forced, 0);
        chk("rst_a_ready",  bus.a_ready,  1);
        chk("rst_b_ready",  bus.b_ready,  1);
        Rst_n = 1'b1;
        tick();

        // ---------------- A only: addrs 1,2,3 ----------------
        for (int i = 1; i <= 3; i++) begin
            bus.a_valid = 1'b1;
            bus.a_addr  = 5'(i);
            bus.a_data  = 32'h1000_0000 + 32'(i);
            #1;
            chk("aonly_a_ready", bus.a_ready, 1);
            tick();
            chk("aonly_rf_we", bus.rf_we,    1);
            chk("aonly_waddr", bus.rf_waddr, i);
            chk("aonly_wdata", bus.rf_wdata, 32'h1000_0000 + i);
            chk("aonly_sel_b", bus.sel_b,    0);
        end
        idle();
        tick();
        chk("idle_rf_we",      bus.rf_we,    0);
        chk("idle_waddr_hold", bus.rf_waddr, 3);

        // ---------------- B only ----------------
        bus.b_valid = 1'b1;
        bus.b_addr  = 5'd31;
        bus.b_data  = 32'h1234_5678;
        #1;
        chk("bonly_b_ready", bus.b_ready, 1);
        tick();
        chk("bonly_rf_we", bus.rf_we,    1);
        chk("bonly_waddr", bus.rf_waddr, 31);
        chk("bonly_wdata", bus.rf_wdata, 32'h1234_5678);
        chk("bonly_sel_b", bus.sel_b,    1);
        idle();

        // ---------------- register 0 ----------------
        bus.a_valid = 1'b1;
        bus.a_addr  = 5'd0;
        bus.a_data  = 32'h0000_00AA;
        #1;
        chk("r0_a_ready", bus.a_ready, 1);
        tick();
        chk("r0_rf_we", bus.rf_we,    0);
        chk("r0_waddr", bus.rf_waddr, 0);
        chk("r0_sel_b", bus.sel_b,    0);
        idle();
        tick();

        // ---------------- contention, MAX_WAIT = 4 and 1 ----------------
        bus.a_valid = 1'b1;
        bus.a_addr  = 5'd3;
        bus.a_data  = 32'hA0A0_A0A0;
        bus.b_valid = 1'b1;
        bus.b_addr  = 5'd9;
        bus.b_data  = 32'hB0B0_B0B0;
        m1_on = 1'b1;
        for (int k = 0; k < 10; k++) begin
            logic f4;
            logic f1;
            f4 = ((k % 5) == 4);
            f1 = ((k % 2) == 1);
            #1;
            chk("ct_b_forced", bus.b_forced, f4);
            chk("ct_a_ready",  bus.a_ready,  !f4);
            chk("ct_b_ready",  bus.b_ready,  f4);
            chk("m1_b_forced", bus1.b_forced, f1);
            tick();
            chk("ct_rf_we",  bus.rf_we,    1);
            chk("ct_sel_b",  bus.sel_b,    f4);
            chk("ct_waddr",  bus.rf_waddr, f4 ? 9 : 3);
            chk("m1_sel_b",  bus1.sel_b,   f1);
            chk("m1_waddr",  bus1.rf_waddr, f1 ? 2 : 1);
        end
        m1_on = 1'b0;

        // ---------------- reset inside FORCE_B ----------------
        // Counter is back at 0 after the last forced grant: 4 A wins first
        tick(); tick(); tick(); tick();
        chk("pre_rst_b_forced", bus.b_forced, 1);
        chk("pre_rst_rf_we",    bus.rf_we,    1);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("arst_rf_we",    bus.rf_we,    0);
        chk("arst_waddr",    bus.rf_waddr, 0);
        chk("arst_wdata",    bus.rf_wdata, 0);
        chk("arst_sel_b",    bus.sel_b,    0);
        chk("arst_b_forced", bus.b_forced, 0);
        idle();
        tick();
        Rst_n = 1'b1;

        // First A transfer after reset
        bus.a_valid = 1'b1;
        bus.a_addr  = 5'd5;
        bus.a_data  = 32'hDEAD_BEEF;
        tick();
        chk("post_rst_rf_we", bus.rf_we,    1);
        chk("post_rst_waddr", bus.rf_waddr, 5);
        chk("post_rst_wdata", bus.rf_wdata, 32'hDEAD_BEEF);
        chk("post_rst_sel_b", bus.sel_b,    0);

        // Contention again: B must wait the full 4 cycles
        bus.b_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rc_b_forced", bus.b_forced, (k == 4));
            tick();
            chk("rc_sel_b", bus.sel_b, (k == 4));
        end
        idle();
        tick();
        chk("end_rf_we", bus.rf_we, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
